ibex_fp_regfile_wb: RTL and testbench

- 32 x 32-bit single-precision FP register file; the receiving end of the FPU writeback interface.
- Supplies three combinational read ports (rs1/rs2/rs3) to the FPU.
- Accepts FPU result writes plus FLW load-data writes. Load writes are buffered in a 2-entry FIFO whenever they collide with an FPU write.
- Keeps a per-register busy scoreboard so the issue stage can stall on RAW hazards.

---
 rtl/ibex_fp_regfile_wb.sv | 134 +++++++++++++
 tb/tb_ibex_fp_regfile_wb.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_fp_regfile_wb.sv
// FP register file with FPU/load writeback arbitration, load buffering and a busy scoreboard.
// Three combinational read ports with write-first bypass of the single commit port.
module ibex_fp_regfile_wb #(
  parameter int unsigned NumRegs    = 32,
  parameter int unsigned LdBufDepth = 2,
  localparam int unsigned AW        = $clog2(NumRegs)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [AW-1:0] raddr_a_i,
  output logic [31:0]   rdata_a_o,
  input  logic [AW-1:0] raddr_b_i,
  output logic [31:0]   rdata_b_o,
  input  logic [AW-1:0] raddr_c_i,
  output logic [31:0]   rdata_c_o,
  output logic          busy_a_o,
  output logic          busy_b_o,
  output logic          busy_c_o,
  input  logic          fpu_we_i,
  input  logic [AW-1:0] fpu_waddr_i,
  input  logic [31:0]   fpu_wdata_i,
  input  logic          ld_valid_i,
  output logic          ld_ready_o,
  input  logic [AW-1:0] ld_waddr_i,
  input  logic [31:0]   ld_wdata_i,
  input  logic          issue_i,
  input  logic [AW-1:0] issue_rd_i
);
  localparam int unsigned CW = $clog2(LdBufDepth + 1);
  localparam int unsigned NP = 3;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wb_t;

  logic [31:0]        rf_q [NumRegs];
  logic [31:0]        rf_d [NumRegs];
  logic [NumRegs-1:0] busy_q, busy_d;
  wb_t                buf_q [LdBufDepth];
  wb_t                buf_d [LdBufDepth];
  wb_t                buf_sh [LdBufDepth];
  logic [CW-1:0]      cnt_q, cnt_d;

  wb_t           ld_ent, cm;
  logic          cm_we, pop, push, ld_acc;
  logic [CW-1:0] wr_idx;

  assign ld_ent     = {ld_waddr_i, ld_wdata_i};
  assign ld_ready_o = (cnt_q < CW'(LdBufDepth));
  assign ld_acc     = ld_valid_i & ld_ready_o;

  // Single commit port: FPU first, then the oldest buffered load, then a direct load.
  always_comb begin
    cm_we = 1'b0;
    cm    = '0;
    pop   = 1'b0;
    push  = 1'b0;
    if (fpu_we_i) begin
      cm_we = 1'b1;
      cm    = {fpu_waddr_i, fpu_wdata_i};
      push  = ld_acc;
    end else if (cnt_q != '0) begin
      cm_we = 1'b1;
      cm    = buf_q[0];
      pop   = 1'b1;
      push  = ld_acc;
    end else if (ld_acc) begin
      cm_we = 1'b1;
      cm    = ld_ent;
    end
  end

  assign wr_idx = cnt_q - CW'(pop);
  assign cnt_d  = cnt_q + CW'(push) - CW'(pop);

  // Shift-register FIFO: head always sits in entry 0.
  for (genvar i = 0; i < LdBufDepth; i++) begin : g_sh
    if (i < LdBufDepth - 1) begin : g_mid
      assign buf_sh[i] = buf_q[i+1];
    end else begin : g_last
      assign buf_sh[i] = '0;
    end
  end

  always_comb begin
    for (int i = 0; i < LdBufDepth; i++) begin
      buf_d[i] = pop ? buf_sh[i] : buf_q[i];
      if (push && (wr_idx == CW'(i))) buf_d[i] = ld_ent;
    end
  end

  always_comb begin
    rf_d = rf_q;
    if (cm_we) rf_d[cm.addr] = cm.data;
  end

  // Issue is applied after the clear so a same-cycle issue keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (cm_we)   busy_d[cm.addr]    = 1'b0;
    if (issue_i) busy_d[issue_rd_i] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumRegs; i++) rf_q[i] <= '0;
      for (int i = 0; i < LdBufDepth; i++) buf_q[i] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      rf_q   <= rf_d;
      buf_q  <= buf_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  logic [NP-1:0][AW-1:0] raddr;
  logic [NP-1:0][31:0]   rdata;
  logic [NP-1:0]         rbusy;

  assign raddr = {raddr_c_i, raddr_b_i, raddr_a_i};

  for (genvar p = 0; p < NP; p++) begin : g_rd
    logic hit;
    assign hit      = cm_we && (cm.addr == raddr[p]);
    assign rdata[p] = hit ? cm.data : rf_q[raddr[p]];
    assign rbusy[p] = busy_q[raddr[p]] & ~hit;
  end

  assign {rdata_c_o, rdata_b_o, rdata_a_o} = rdata;
  assign {busy_c_o, busy_b_o, busy_a_o}    = rbusy;
endmodule

// File: tb/tb_ibex_fp_regfile_wb.sv
// Bench for ibex_fp_regfile_wb: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_ibex_fp_regfile_wb;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  raddr_a, raddr_b, raddr_c;
  logic [31:0] rdata_a, rdata_b, rdata_c;
  logic        busy_a, busy_b, busy_c;
  logic        fpu_we;
  logic [4:0]  fpu_waddr;
  logic [31:0] fpu_wdata;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_waddr;
  logic [31:0] ld_wdata;
  logic        issue;
  logic [4:0]  issue_rd;

  int total = 0;
  int bad   = 0;

  ibex_fp_regfile_wb #(.NumRegs(32), .LdBufDepth(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .raddr_a_i(raddr_a), .rdata_a_o(rdata_a),
    .raddr_b_i(raddr_b), .rdata_b_o(rdata_b),
    .raddr_c_i(raddr_c), .rdata_c_o(rdata_c),
    .busy_a_o(busy_a), .busy_b_o(busy_b), .busy_c_o(busy_c),
    .fpu_we_i(fpu_we), .fpu_waddr_i(fpu_waddr), .fpu_wdata_i(fpu_wdata),
    .ld_valid_i(ld_valid), .ld_ready_o(ld_ready),
    .ld_waddr_i(ld_waddr), .ld_wdata_i(ld_wdata),
    .issue_i(issue), .issue_rd_i(issue_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain register array, busy array and a queue of pending loads.
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ld_t;

  logic [31:0] m_rf [32];
  bit          m_busy [32];
  ld_t         m_q [$];
  bit          m_ok = 0;

  task automatic model_commit(output bit we, output logic [4:0] a, output logic [31:0] d,
                              output bit pop, output bit push);
    bit acc;
    acc = ld_valid && (m_q.size() < DEPTH);
    we = 0; a = '0; d = '0; pop = 0; push = 0;
    if (fpu_we) begin
      we = 1; a = fpu_waddr; d = fpu_wdata; push = acc;
    end else if (m_q.size() > 0) begin
      we = 1; a = m_q[0].a; d = m_q[0].d; pop = 1; push = acc;
    end else if (acc) begin
      we = 1; a = ld_waddr; d = ld_wdata;
    end
  endtask

  always @(posedge clk) begin
    bit we, pop, push;
    logic [4:0] a;
    logic [31:0] d;
    ld_t e;
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin m_rf[i] = '0; m_busy[i] = 0; end
      m_q.delete();
      m_ok = 1;
    end else begin
      model_commit(we, a, d, pop, push);
      e.a = ld_waddr; e.d = ld_wdata;
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back(e);
      if (we) begin m_rf[a] = d; m_busy[a] = 0; end
      if (issue) m_busy[issue_rd] = 1;
    end
  end

  always @(negedge clk) begin
    bit we, pop, push;
    logic [4:0] a;
    logic [31:0] d;
    if (m_ok) begin
      model_commit(we, a, d, pop, push);
      chk("model rdata_a", rdata_a, (we && a == raddr_a) ? d : m_rf[raddr_a]);
      chk("model rdata_b", rdata_b, (we && a == raddr_b) ? d : m_rf[raddr_b]);
      chk("model rdata_c", rdata_c, (we && a == raddr_c) ? d : m_rf[raddr_c]);
      chk("model busy_a", 32'(busy_a), 32'(m_busy[raddr_a] && !(we && a == raddr_a)));
      chk("model busy_b", 32'(busy_b), 32'(m_busy[raddr_b] && !(we && a == raddr_b)));
      chk("model busy_c", 32'(busy_c), 32'(m_busy[raddr_c] && !(we && a == raddr_c)));
      chk("model ld_ready", 32'(ld_ready), 32'(m_q.size() < DEPTH));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fpu_we = 0; fpu_waddr = '0; fpu_wdata = '0;
    ld_valid = 0; ld_waddr = '0; ld_wdata = '0;
    issue = 0; issue_rd = '0;
  endtask

  task automatic ld(input logic [4:0] a, input logic [31:0] d);
    ld_valid = 1; ld_waddr = a; ld_wdata = d;
  endtask

  task automatic fpu(input logic [4:0] a, input logic [31:0] d);
    fpu_we = 1; fpu_waddr = a; fpu_wdata = d;
  endtask

  initial begin
    rst_n = 0; idle();
    raddr_a = '0; raddr_b = '0; raddr_c = '0;
    tick(); tick();
    rst_n = 1;

    // 1: post-reset contents
    for (int i = 0; i < 32; i++) begin
      raddr_a = 5'(i); raddr_b = 5'(i); raddr_c = 5'(i);
      #2;
      chk("reset rdata_a", rdata_a, 32'h0);
      chk("reset rdata_c", rdata_c, 32'h0);
      chk("reset busy_b", 32'(busy_b), 32'h0);
      if (i == 0) chk("reset ld_ready", 32'(ld_ready), 32'h1);
      tick();
    end

    // 2: direct loads with same-cycle bypass
    ld(5'd1, 32'h4023d70a); raddr_a = 5'd1; #2;
    chk("ld f1 bypass", rdata_a, 32'h4023d70a);
    tick();
    ld(5'd2, 32'h41200000); raddr_b = 5'd2; #2;
    chk("ld f1 array", rdata_a, 32'h4023d70a);
    chk("ld f2 bypass", rdata_b, 32'h41200000);
    tick();
    idle(); #2;
    chk("ld f2 array", rdata_b, 32'h41200000);
    tick();

    // 3: scoreboard set by issue, cleared by commit
    issue = 1; issue_rd = 5'd3; raddr_a = 5'd3; tick();
    idle(); #2;
    chk("busy f3 set", 32'(busy_a), 32'h1);
    tick();
    fpu(5'd3, 32'h4148f5c3); #2;
    chk("busy f3 clr bypass", 32'(busy_a), 32'h0);
    chk("fpu f3 bypass", rdata_a, 32'h4148f5c3);
    tick();
    idle(); #2;
    chk("busy f3 cleared", 32'(busy_a), 32'h0);
    tick();

    // 4: loads buffered behind a 4-cycle FPU burst
    fpu(5'd10, 32'h000000f1); ld(5'd11, 32'haaaa0001); #2;
    chk("burst ready c1", 32'(ld_ready), 32'h1);
    tick();
    fpu(5'd10, 32'h000000f2); ld(5'd12, 32'hbbbb0002); #2;
    chk("burst ready c2", 32'(ld_ready), 32'h1);
    tick();
    fpu(5'd10, 32'h000000f3); ld(5'd13, 32'hcccc0003); #2;
    chk("burst full c3", 32'(ld_ready), 32'h0);
    tick();
    fpu(5'd10, 32'h000000f4); #2;
    chk("burst full c4", 32'(ld_ready), 32'h0);
    tick();
    fpu_we = 0; raddr_a = 5'd11; #2;
    chk("drain f11", rdata_a, 32'haaaa0001);
    chk("drain ready c5", 32'(ld_ready), 32'h0);
    tick();
    raddr_b = 5'd12; #2;
    chk("drain f12", rdata_b, 32'hbbbb0002);
    chk("drain ready c6", 32'(ld_ready), 32'h1);
    tick();
    idle(); raddr_c = 5'd13; #2;
    chk("drain f13", rdata_c, 32'hcccc0003);
    tick();
    raddr_a = 5'd10; raddr_b = 5'd11; #2;
    chk("burst f10 final", rdata_a, 32'h000000f4);
    chk("f11 array", rdata_b, 32'haaaa0001);
    chk("f13 array", rdata_c, 32'hcccc0003);
    tick();

    // 5: FPU and load to the same register in one cycle; load lands last
    fpu(5'd5, 32'hc0f8a3d7); ld(5'd5, 32'h3f800000); raddr_a = 5'd5; #2;
    chk("f5 fpu bypass", rdata_a, 32'hc0f8a3d7);
    tick();
    idle(); #2;
    chk("f5 load bypass", rdata_a, 32'h3f800000);
    tick();
    #2;
    chk("f5 final", rdata_a, 32'h3f800000);
    tick();

    // 6: issue beats commit; reset flushes buffered loads and busy bits
    issue = 1; issue_rd = 5'd7; fpu(5'd7, 32'h12345678); raddr_a = 5'd7; #2;
    chk("f7 busy same cycle", 32'(busy_a), 32'h0);
    tick();
    idle(); #2;
    chk("f7 busy kept", 32'(busy_a), 32'h1);
    chk("f7 data", rdata_a, 32'h12345678);
    tick();
    fpu(5'd8, 32'h88888888); ld(5'd20, 32'h20202020); tick();
    fpu(5'd8, 32'h88888889); ld(5'd21, 32'h21212121); #2;
    chk("pre-rst ready", 32'(ld_ready), 32'h1);
    tick();
    idle(); rst_n = 0; raddr_b = 5'd20; raddr_c = 5'd21; #2;
    chk("pre-rst full", 32'(ld_ready), 32'h0);
    tick();
    rst_n = 1; #2;
    chk("post-rst ready", 32'(ld_ready), 32'h1);
    chk("post-rst busy f7", 32'(busy_a), 32'h0);
    chk("post-rst f7", rdata_a, 32'h0);
    chk("post-rst f20", rdata_b, 32'h0);
    chk("post-rst f21", rdata_c, 32'h0);
    tick();
    #2;
    chk("flushed f20", rdata_b, 32'h0);
    chk("flushed f21", rdata_c, 32'h0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
